// File: rtl/shared_timer_arbiter_pkg.sv
// Shared definitions for the round-robin interval timer arbiter.
package shared_timer_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  // Width of a requester index; at least one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_timer_counter.sv
// Shared up counter: synchronous reset, clear (load 0) over increment.
module shared_timer_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/shared_timer_arbiter.sv
// Round-robin arbiter sharing one interval counter among N_REQ requesters.
module shared_timer_arbiter
  import shared_timer_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       cnt_q
);

  localparam int unsigned IW = idx_w(N_REQ);

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [IW-1:0]    last, last_n;
  logic [IW-1:0]    pick;
  logic [CNT_W-1:0] tc, tc_n;
  logic [N_REQ-1:0] rot;
  logic             found;
  logic             clr;
  logic             en;

  shared_timer_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en (en),
    .cnt(cnt_q)
  );

  // Rotate so last+1 sits at bit 0, take the lowest set bit, then map back.
  always_comb begin
    rot   = '0;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++)
      rot[i] = req[(32'(last) + 1 + i) % N_REQ];
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pick  = IW'((32'(last) + 1 + i) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      last  <= IW'(N_REQ - 1);
      tc    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      last  <= last_n;
      tc    <= tc_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    last_n  = last;
    tc_n    = tc;
    grant   = '0;
    done    = '0;
    clr     = 1'b0;
    en      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          idx_n   = pick;
          last_n  = pick;
          tc_n    = len[32'(pick)*CNT_W +: CNT_W];
          clr     = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        grant[idx] = 1'b1;
        if (!req[idx])
          state_n = IDLE;
        else if (cnt_q == tc)
          state_n = DONE;
        else
          en = 1'b1;
      end
      DONE: begin
        done[idx] = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Self-checking bench for shared_timer_arbiter (N_REQ=4, CNT_W=8).
module tb_shared_timer_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   cnt_q;

  int checks = 0;
  int errors = 0;

  // Session-level reference: who owns the timer, how far it has counted,
  // who is owed a done pulse, and who won last.
  int          m_owner = -1;
  int          m_done  = -1;
  int          m_last  = N - 1;
  int unsigned m_cnt   = 0;
  int unsigned m_tc    = 0;

  typedef struct {
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic [N-1:0]   g;
    logic [N-1:0]   d;
    logic           b;
    logic [W-1:0]   c;
  } vec_t;

  vec_t tbl[8];

  shared_timer_arbiter #(
    .N_REQ(N),
    .CNT_W(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .grant(grant),
    .done (done),
    .busy (busy),
    .cnt_q(cnt_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] one = 1;
    return (i < 0) ? '0 : (one << i);
  endfunction

  task automatic model_step();
    if (rst) begin
      m_owner = -1; m_done = -1; m_cnt = 0; m_tc = 0; m_last = N - 1;
    end else if (m_done >= 0) begin
      m_done = -1;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) m_owner = -1;
      else if (m_cnt == m_tc) begin m_done = m_owner; m_owner = -1; end
      else m_cnt++;
    end else if (req != 0) begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_last + k) % N;
        if (req[p]) begin
          m_owner = p; m_last = p; m_cnt = 0;
          m_tc = len[p*W +: W];
          break;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("model_grant", grant, onehot(m_owner));
    chk("model_done",  done,  onehot(m_done));
    chk("model_busy",  busy,  (m_owner >= 0 || m_done >= 0));
    chk("model_cnt",   cnt_q, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_len(input int i, input int v);
    len[i*W +: W] = W'(v);
  endtask

  initial begin
    int cyc;
    int gcnt;
    int order[$];
    logic [N-1:0] prev_g;
    logic [W-1:0] maxc;

    rst = 1'b1; req = '1; len = '0;

    // Reset held with all requests, then a len=0 session for requester 1.
    tbl[0] = '{1'b1, 4'b1111, '0, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 4'b1111, '0, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 4'b1111, '0, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 4'b0000, '0, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[4] = '{1'b0, 4'b0010, '0, 4'b0010, 4'b0000, 1'b1, 8'd0};
    tbl[5] = '{1'b0, 4'b0010, '0, 4'b0000, 4'b0010, 1'b1, 8'd0};
    tbl[6] = '{1'b0, 4'b0000, '0, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[7] = '{1'b0, 4'b0000, '0, 4'b0000, 4'b0000, 1'b0, 8'd0};
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; len = tbl[i].len;
      tick();
      chk($sformatf("vec%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("vec%0d_done", i),  done,  tbl[i].d);
      chk($sformatf("vec%0d_busy", i),  busy,  tbl[i].b);
      chk($sformatf("vec%0d_cnt", i),   cnt_q, tbl[i].c);
    end

    // Single requester 0, len 5: six grant cycles, then done, then idle.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0001; set_len(0, 5);
    gcnt = 0; cyc = 0;
    while (done == 0 && cyc < 40) begin
      tick(); cyc++;
      if (grant == 4'b0001) begin
        chk("t2_cnt_step", cnt_q, gcnt);
        gcnt++;
      end
    end
    chk("t2_done_seen", done, 4'b0001);
    chk("t2_grant_cycles", gcnt, 6);
    req = '0;
    tick();
    chk("t2_idle_busy", busy, 1'b0);

    // All request with len 2: strict rotation 0,1,2,3,0.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; len = {8'd2, 8'd2, 8'd2, 8'd2};
    prev_g = '0; cyc = 0;
    while (order.size() < 5 && cyc < 80) begin
      tick(); cyc++;
      if (prev_g == 0 && grant != 0)
        for (int j = 0; j < N; j++) if (grant[j]) order.push_back(j);
      prev_g = grant;
    end
    chk("t3_sessions", order.size(), 5);
    for (int j = 0; j < order.size() && j < 5; j++)
      chk($sformatf("t3_order%0d", j), order[j], j % N);
    req = '0; tick(); tick(); tick(); tick();

    // Abort: requester 2 drops its request at cnt_q=4.
    req = 4'b0100; set_len(2, 10); cyc = 0;
    do begin tick(); cyc++; end while (!(grant == 4'b0100 && cnt_q == 4) && cyc < 40);
    chk("t5_reach_cnt4", cnt_q, 4);
    req = '0;
    tick();
    chk("t5_grant", grant, 4'b0000);
    chk("t5_done",  done,  4'b0000);
    chk("t5_busy",  busy,  1'b0);
    tick();
    chk("t5_no_late_done", done, 4'b0000);

    // Reset mid-session, then requester 0 must win first.
    req = 4'b0100; set_len(2, 8); cyc = 0;
    do begin tick(); cyc++; end while (!(grant == 4'b0100 && cnt_q == 3) && cyc < 40);
    chk("t6_reach_cnt3", cnt_q, 3);
    rst = 1'b1;
    tick();
    chk("t6_grant", grant, 4'b0000);
    chk("t6_done",  done,  4'b0000);
    chk("t6_busy",  busy,  1'b0);
    chk("t6_cnt",   cnt_q, 0);
    rst = 1'b0; req = 4'b1111;
    tick();
    chk("t6_first_winner", grant, 4'b0001);
    req = '0; tick(); tick();

    // Full-range count: cnt_q climbs to 255 with no wrap.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0001; set_len(0, 255);
    maxc = '0; gcnt = 0; cyc = 0;
    while (done == 0 && cyc < 400) begin
      tick(); cyc++;
      if (grant == 4'b0001) begin
        if (cnt_q > maxc) maxc = cnt_q;
        gcnt++;
      end
    end
    chk("t7_max_cnt", maxc, 255);
    chk("t7_grant_cycles", gcnt, 256);
    chk("t7_done", done, 4'b0001);
    req = '0; tick();

    // Random traffic, random len changes, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 9) < 2) req[j] = ~req[j];
        set_len(j, $urandom_range(0, 7));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
